// File: rtl/measure_pkg.sv
// Shared types for the measurement channel scheduler: counter widths, FSM states
// and the per-channel result record.
package measure_pkg;

    localparam int PERIOD_W = 26;
    localparam int HIGH_W   = 20;
    localparam int CH_MAX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ARM,
        MEASURE,
        LATCH,
        ABORT,
        REPORT,
        NEXT
    } state_t;

    typedef struct packed {
        logic [CH_MAX_W-1:0] ch;
        logic [PERIOD_W-1:0] period;
        logic [HIGH_W-1:0]   high;
        logic [PERIOD_W-1:0] low;
        logic                timeout;
    } result_t;

    // Low time floors at zero so a glitchy engine reading never wraps.
    function automatic logic [PERIOD_W-1:0] calc_low(input logic [PERIOD_W-1:0] period,
                                                     input logic [HIGH_W-1:0]   high);
        logic [PERIOD_W-1:0] high_ext;
        high_ext = PERIOD_W'(high);
        return (high_ext > period) ? '0 : (period - high_ext);
    endfunction

endpackage

// File: rtl/measure_channel_scheduler_if.sv
// Link between the channel scheduler (master) and the single measurement engine (slave).
interface measure_channel_scheduler_if #(
    parameter int NUM_CH = 4
);
    import measure_pkg::*;

    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0]     meas_sel;
    logic                meas_enable;
    logic                meas_rst_n;
    logic                meas_busy;
    logic                meas_finish;
    logic [PERIOD_W-1:0] meas_period;
    logic [HIGH_W-1:0]   meas_high;

    modport master (
        output meas_sel, meas_enable, meas_rst_n,
        input  meas_busy, meas_finish, meas_period, meas_high
    );

    modport slave (
        input  meas_sel, meas_enable, meas_rst_n,
        output meas_busy, meas_finish, meas_period, meas_high
    );

endinterface

// File: rtl/meas_next_ch.sv
// Finds the lowest set mask bit at or above (inclusive=1) or strictly above
// (inclusive=0) a given channel index.
module meas_next_ch
    import measure_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   from,
    input  logic              inclusive,
    output logic [CH_W-1:0]   ch,
    output logic              found
);

    // Scanning downward leaves the lowest qualifying index as the final winner.
    always_comb begin
        ch    = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (inclusive ? (i >= int'(from)) : (i > int'(from)))) begin
                ch    = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/measure_channel_scheduler.sv
// Time-shares one period/duty measurement engine across NUM_CH inputs, sweeping the
// enabled channels and recovering the engine by pulsing its reset when a channel is dead.
module measure_channel_scheduler
    import measure_pkg::*;
#(
    parameter  int          NUM_CH         = 4,
    parameter  int unsigned SETTLE_CYCLES  = 4,
    parameter  int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter  int unsigned ABORT_CYCLES   = 2,
    localparam int          CH_W           = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                continuous,
    input  logic [NUM_CH-1:0]   ch_mask,
    measure_channel_scheduler_if.master meas,
    output logic                sched_busy,
    output logic                sweep_done,
    output logic                res_valid,
    output logic [CH_W-1:0]     res_ch,
    output logic [PERIOD_W-1:0] res_period,
    output logic [HIGH_W-1:0]   res_high,
    output logic [PERIOD_W-1:0] res_low,
    output logic                res_timeout,
    output logic [NUM_CH-1:0]   ch_timeout
);

    state_t              state;
    state_t              state_next;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     sel_q;
    logic [31:0]         step_cnt;
    logic [31:0]         tmo_cnt;
    result_t             res_q;
    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     next_ch;
    logic                first_found;
    logic                next_found;
    logic                unused_bits;

    meas_next_ch #(.NUM_CH(NUM_CH)) u_first (
        .mask      (ch_mask),
        .from      ({CH_W{1'b0}}),
        .inclusive (1'b1),
        .ch        (first_ch),
        .found     (first_found)
    );

    meas_next_ch #(.NUM_CH(NUM_CH)) u_next (
        .mask      (mask_q),
        .from      (sel_q),
        .inclusive (1'b0),
        .ch        (next_ch),
        .found     (next_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Finish wins over the timeout compare when both land in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && first_found) state_next = SETTLE;
            SETTLE:  if (step_cnt == SETTLE_CYCLES - 1) state_next = ARM;
            ARM:     state_next = MEASURE;
            MEASURE: begin
                if (meas.meas_finish)                    state_next = LATCH;
                else if (tmo_cnt == TIMEOUT_CYCLES - 1)  state_next = ABORT;
            end
            LATCH:   state_next = REPORT;
            ABORT:   if (step_cnt == ABORT_CYCLES - 1) state_next = REPORT;
            REPORT:  state_next = NEXT;
            NEXT: begin
                if (next_found)                     state_next = SETTLE;
                else if (continuous && first_found) state_next = SETTLE;
                else                                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            sel_q      <= '0;
            step_cnt   <= '0;
            tmo_cnt    <= '0;
            res_q      <= '0;
            res_valid  <= 1'b0;
            sweep_done <= 1'b0;
            sched_busy <= 1'b0;
            ch_timeout <= '0;
        end else begin
            res_valid  <= 1'b0;
            sweep_done <= 1'b0;

            if (state_next != state)
                step_cnt <= '0;
            else if (state == SETTLE || state == ABORT)
                step_cnt <= step_cnt + 32'd1;

            if (state == ARM)
                tmo_cnt <= '0;
            else if (state == MEASURE)
                tmo_cnt <= tmo_cnt + 32'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q     <= ch_mask;
                        ch_timeout <= '0;
                        sched_busy <= 1'b1;
                        if (first_found) sel_q      <= first_ch;
                        else             sweep_done <= 1'b1;
                    end else begin
                        sched_busy <= 1'b0;
                    end
                end
                LATCH: begin
                    res_q.ch      <= CH_MAX_W'(sel_q);
                    res_q.period  <= meas.meas_period;
                    res_q.high    <= meas.meas_high;
                    res_q.low     <= calc_low(meas.meas_period, meas.meas_high);
                    res_q.timeout <= 1'b0;
                end
                ABORT: begin
                    res_q.ch          <= CH_MAX_W'(sel_q);
                    res_q.period      <= '0;
                    res_q.high        <= '0;
                    res_q.low         <= '0;
                    res_q.timeout     <= 1'b1;
                    ch_timeout[sel_q] <= 1'b1;
                end
                REPORT: res_valid <= 1'b1;
                NEXT: begin
                    if (next_found) begin
                        sel_q <= next_ch;
                    end else begin
                        sweep_done <= 1'b1;
                        if (continuous && first_found) begin
                            mask_q     <= ch_mask;
                            ch_timeout <= '0;
                            sel_q      <= first_ch;
                        end else begin
                            sched_busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The integrating top ANDs meas_rst_n with rst_n; here it only reflects the abort window.
    assign meas.meas_sel    = sel_q;
    assign meas.meas_enable = (state == ARM);
    assign meas.meas_rst_n  = (state != ABORT);

    assign res_ch      = res_q.ch[CH_W-1:0];
    assign res_period  = res_q.period;
    assign res_high    = res_q.high;
    assign res_low     = res_q.low;
    assign res_timeout = res_q.timeout;

    // Completion is judged by finish or timeout only; engine busy is informational.
    assign unused_bits = ^{meas.meas_busy, res_q.ch};

endmodule

// File: tb/tb_measure_channel_scheduler.sv
// Directed bench for measure_channel_scheduler; the bench plays the measurement engine
// and checks sweeps, timeouts, empty masks, continuous mode and mid-run reset.
module tb_measure_channel_scheduler;

    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [3:0]  ch_mask = 4'b0000;
    logic        sched_busy;
    logic        sweep_done;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [25:0] res_period;
    logic [19:0] res_high;
    logic [25:0] res_low;
    logic        res_timeout;
    logic [3:0]  ch_timeout;

    int test_cnt = 0;
    int fail_cnt = 0;

    measure_channel_scheduler_if #(.NUM_CH(NUM_CH)) bus();

    measure_channel_scheduler #(
        .NUM_CH         (NUM_CH),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1000),
        .ABORT_CYCLES   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .ch_mask     (ch_mask),
        .meas        (bus),
        .sched_busy  (sched_busy),
        .sweep_done  (sweep_done),
        .res_valid   (res_valid),
        .res_ch      (res_ch),
        .res_period  (res_period),
        .res_high    (res_high),
        .res_low     (res_low),
        .res_timeout (res_timeout),
        .ch_timeout  (ch_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] mask, input logic cont);
        ch_mask    = mask;
        continuous = cont;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_enable(input string tag, input logic [1:0] exp_sel, input int exp_wait);
        int n;
        int stray;
        n = 0;
        stray = 0;
        while (bus.meas_enable !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (res_valid === 1'b1) stray++;
        end
        check_output({tag, "_enable"}, bus.meas_enable, 1);
        check_output({tag, "_sel"}, bus.meas_sel, exp_sel);
        check_output({tag, "_wait"}, n, exp_wait);
        check_output({tag, "_stray_valid"}, stray, 0);
    endtask

    // Called at the arm cycle; finish is sampled d cycles later, results follow one cycle after.
    task automatic finish_engine(input string tag, input int d, input logic [25:0] per,
                                 input logic [19:0] hi, input logic [1:0] exp_ch,
                                 input logic [25:0] exp_low);
        int aborts;
        aborts = 0;
        bus.meas_busy = 1'b1;
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (bus.meas_rst_n === 1'b0) aborts++;
        end
        bus.meas_finish = 1'b1;
        bus.meas_period = '1;
        bus.meas_high   = '1;
        @(negedge clk);
        bus.meas_finish = 1'b0;
        bus.meas_busy   = 1'b0;
        bus.meas_period = per;
        bus.meas_high   = hi;
        @(negedge clk);
        check_output({tag, "_valid_early"}, res_valid, 0);
        @(negedge clk);
        check_output({tag, "_valid"}, res_valid, 1);
        check_output({tag, "_ch"}, res_ch, exp_ch);
        check_output({tag, "_period"}, res_period, per);
        check_output({tag, "_high"}, res_high, hi);
        check_output({tag, "_low"}, res_low, exp_low);
        check_output({tag, "_timeout"}, res_timeout, 0);
        check_output({tag, "_no_abort"}, aborts, 0);
    endtask

    initial begin
        int n;
        int extra_done;
        int extra_en;

        bus.meas_busy   = 1'b0;
        bus.meas_finish = 1'b0;
        bus.meas_period = '0;
        bus.meas_high   = '0;

        repeat (2) @(negedge clk);
        check_output("rst_busy", sched_busy, 0);
        check_output("rst_meas_rst_n", bus.meas_rst_n, 1);
        check_output("rst_enable", bus.meas_enable, 0);
        check_output("rst_valid", res_valid, 0);
        check_output("rst_done", sweep_done, 0);
        check_output("rst_ch_timeout", ch_timeout, 0);
        check_output("rst_period", res_period, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sweep over ch0 and ch2; a mid-sweep mask change and start must not disturb it.
        apply_stimulus(4'b0101, 1'b0);
        check_output("sw_busy", sched_busy, 1);
        ch_mask = 4'b1111;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_enable("sw_ch0", 2'd0, 3);
        finish_engine("sw_ch0", 20, 26'd400000, 20'd100000, 2'd0, 26'd300000);
        check_output("sw_ch0_no_done", sweep_done, 0);
        wait_enable("sw_ch2", 2'd2, 5);
        finish_engine("sw_ch2", 7, 26'd40000, 20'd20000, 2'd2, 26'd20000);
        @(negedge clk);
        check_output("sw_done", sweep_done, 1);
        check_output("sw_busy_end", sched_busy, 0);
        check_output("sw_valid_gone", res_valid, 0);
        check_output("sw_hold_period", res_period, 40000);
        ch_mask = 4'b0000;

        // Dead input on ch1.
        apply_stimulus(4'b0010, 1'b0);
        wait_enable("tmo", 2'd1, 4);
        n = 0;
        while (bus.meas_rst_n !== 1'b0 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check_output("tmo_abort_cycle", n, 1001);
        check_output("tmo_rst_low1", bus.meas_rst_n, 0);
        @(negedge clk);
        check_output("tmo_rst_low2", bus.meas_rst_n, 0);
        @(negedge clk);
        check_output("tmo_rst_release", bus.meas_rst_n, 1);
        check_output("tmo_valid_early", res_valid, 0);
        @(negedge clk);
        check_output("tmo_valid", res_valid, 1);
        check_output("tmo_flag", res_timeout, 1);
        check_output("tmo_ch", res_ch, 1);
        check_output("tmo_period", res_period, 0);
        check_output("tmo_high", res_high, 0);
        check_output("tmo_low", res_low, 0);
        check_output("tmo_ch_timeout", ch_timeout, 4'b0010);
        @(negedge clk);
        check_output("tmo_done", sweep_done, 1);
        check_output("tmo_sticky", ch_timeout, 4'b0010);

        // Empty mask: immediate sweep_done, no arm.
        apply_stimulus(4'b0000, 1'b0);
        check_output("empty_done", sweep_done, 1);
        check_output("empty_busy", sched_busy, 1);
        check_output("empty_clear_tmo", ch_timeout, 0);
        check_output("empty_no_enable", bus.meas_enable, 0);
        @(negedge clk);
        check_output("empty_done_gone", sweep_done, 0);
        check_output("empty_busy_end", sched_busy, 0);

        // Continuous sweeps on ch3, low floors at zero, stray finish ignored, then stop.
        apply_stimulus(4'b1000, 1'b1);
        wait_enable("cont1", 2'd3, 4);
        finish_engine("cont1", 5, 26'd100, 20'd150, 2'd3, 26'd0);
        @(negedge clk);
        check_output("cont1_done", sweep_done, 1);
        check_output("cont1_busy", sched_busy, 1);
        bus.meas_finish = 1'b1;
        @(negedge clk);
        bus.meas_finish = 1'b0;
        wait_enable("cont2", 2'd3, 3);
        continuous = 1'b0;
        finish_engine("cont2", 5, 26'd300, 20'd100, 2'd3, 26'd200);
        @(negedge clk);
        check_output("cont2_done", sweep_done, 1);
        check_output("cont2_busy", sched_busy, 0);
        extra_done = 0;
        extra_en   = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sweep_done === 1'b1) extra_done++;
            if (bus.meas_enable === 1'b1) extra_en++;
        end
        check_output("cont_stop_done", extra_done, 0);
        check_output("cont_stop_enable", extra_en, 0);
        ch_mask = 4'b0000;

        // Finish arrives in the very cycle the timeout compare hits.
        apply_stimulus(4'b0100, 1'b0);
        wait_enable("tie", 2'd2, 4);
        finish_engine("tie", 1000, 26'd1234, 20'd234, 2'd2, 26'd1000);
        @(negedge clk);
        check_output("tie_done", sweep_done, 1);
        check_output("tie_ch_timeout", ch_timeout, 0);

        // Reset asserted while measuring, then a normal sweep.
        apply_stimulus(4'b0100, 1'b0);
        wait_enable("rst_mid", 2'd2, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_sel", bus.meas_sel, 0);
        check_output("rst_mid_busy", sched_busy, 0);
        check_output("rst_mid_period", res_period, 0);
        check_output("rst_mid_high", res_high, 0);
        check_output("rst_mid_low", res_low, 0);
        check_output("rst_mid_ch", res_ch, 0);
        check_output("rst_mid_enable", bus.meas_enable, 0);
        check_output("rst_mid_meas_rst_n", bus.meas_rst_n, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(4'b0010, 1'b0);
        wait_enable("post_rst", 2'd1, 4);
        finish_engine("post_rst", 10, 26'd5000, 20'd1250, 2'd1, 26'd3750);
        @(negedge clk);
        check_output("post_rst_done", sweep_done, 1);
        check_output("post_rst_busy", sched_busy, 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
